wb_stage: RTL and testbench

Writeback stage that drives the register file write port (`Rw`, `RegWr`, `busW`). It captures MEM-stage results in a MEM/WB pipeline register and selects ALU result or load data. It applies byte/halfword load extraction with sign/zero extension, suppresses writes to register 0 and misaligned loads, and exposes the captured write for forwarding. It sits between data memory and the register file in the 5-stage pipeline.

---
 rtl/cpu_pkg.sv | 14 +
 rtl/wb_stage_if.sv | 40 ++++
 rtl/wb_stage_load_ext.sv | 53 +++++
 rtl/wb_stage.sv | 74 +++++++
 tb/tb_wb_stage.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU constants: datapath/register-address defaults and load-op encoding.
package cpu_pkg;

  localparam int CPU_DW    = 32;
  localparam int CPU_AW    = 5;
  localparam int LOAD_OP_W = 3;

  localparam logic [LOAD_OP_W-1:0] LW  = 3'b000;
  localparam logic [LOAD_OP_W-1:0] LB  = 3'b001;
  localparam logic [LOAD_OP_W-1:0] LBU = 3'b010;
  localparam logic [LOAD_OP_W-1:0] LH  = 3'b011;
  localparam logic [LOAD_OP_W-1:0] LHU = 3'b100;

endpackage

// File: rtl/wb_stage_if.sv
// MEM-to-WB handshake bundle: pipeline control, MEM-stage results and
// the register-file write port driven by the writeback stage.
interface wb_stage_if
  import cpu_pkg::*;
#(
  parameter int DW = CPU_DW,
  parameter int AW = CPU_AW
);

  logic                 Run;
  logic                 Stall;
  logic                 Flush;
  logic                 M_Valid;
  logic                 M_RegWr;
  logic                 M_MemtoReg;
  logic [LOAD_OP_W-1:0] M_LoadOp;
  logic [AW-1:0]        M_Rw;
  logic [DW-1:0]        M_AluOut;
  logic [DW-1:0]        M_MemData;

  logic [AW-1:0]        Rw;
  logic                 RegWr;
  logic [DW-1:0]        busW;
  logic                 W_Valid;
  logic                 AddrErr;
  logic [31:0]          RetireCnt;

  modport master (
    output Run, Stall, Flush, M_Valid, M_RegWr, M_MemtoReg, M_LoadOp,
           M_Rw, M_AluOut, M_MemData,
    input  Rw, RegWr, busW, W_Valid, AddrErr, RetireCnt
  );

  modport slave (
    input  Run, Stall, Flush, M_Valid, M_RegWr, M_MemtoReg, M_LoadOp,
           M_Rw, M_AluOut, M_MemData,
    output Rw, RegWr, busW, W_Valid, AddrErr, RetireCnt
  );

endinterface

// File: rtl/wb_stage_load_ext.sv
// Load extraction: picks the addressed byte/half out of an aligned word,
// sign- or zero-extends it, and flags misaligned word/half accesses.
module load_ext
  import cpu_pkg::*;
#(
  parameter int DW = CPU_DW
) (
  input  logic [DW-1:0]        raw,
  input  logic [LOAD_OP_W-1:0] op,
  input  logic [1:0]           addr,
  output logic [DW-1:0]        data,
  output logic                 misaligned
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Little-endian lane selection from the low address bits
  always_comb begin
    byte_sel = raw[7:0];
    case (addr)
      2'd0: byte_sel = raw[7:0];
      2'd1: byte_sel = raw[15:8];
      2'd2: byte_sel = raw[23:16];
      2'd3: byte_sel = raw[31:24];
      default: byte_sel = raw[7:0];
    endcase
    half_sel = addr[1] ? raw[31:16] : raw[15:0];
  end

  // Extension and alignment check; unused op codes behave as a word load
  always_comb begin
    data       = raw;
    misaligned = 1'b0;
    case (op)
      LB:  data = {{(DW-8){byte_sel[7]}}, byte_sel};
      LBU: data = {{(DW-8){1'b0}}, byte_sel};
      LH: begin
        data       = {{(DW-16){half_sel[15]}}, half_sel};
        misaligned = addr[0];
      end
      LHU: begin
        data       = {{(DW-16){1'b0}}, half_sel};
        misaligned = addr[0];
      end
      default: begin
        data       = raw;
        misaligned = (addr != 2'd0);
      end
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: MEM/WB pipeline register feeding the register-file write
// port. Optional retired-instruction counter enabled by WB_RETIRE_CNT_EN;
// without it RetireCnt reads as 0.
module wb_stage
  import cpu_pkg::*;
#(
  parameter int DW = CPU_DW,
  parameter int AW = CPU_AW
) (
  input  logic        Clk,
  input  logic        Rst,
  wb_stage_if.slave   wb
);

  logic [DW-1:0] ext_data;
  logic          ext_mis;
  logic          misaligned;
  logic          capture;

  load_ext #(.DW(DW)) u_load_ext (
    .raw        (wb.M_MemData),
    .op         (wb.M_LoadOp),
    .addr       (wb.M_AluOut[1:0]),
    .data       (ext_data),
    .misaligned (ext_mis)
  );

  // Alignment only matters when the result actually comes from memory
  assign misaligned = wb.M_MemtoReg & ext_mis;
  assign capture    = wb.Run & ~wb.Flush & ~wb.Stall;

  // MEM/WB register: flush beats stall beats normal capture, all gated by Run
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      wb.W_Valid <= 1'b0;
      wb.RegWr   <= 1'b0;
      wb.AddrErr <= 1'b0;
      wb.Rw      <= '0;
      wb.busW    <= '0;
    end else if (wb.Run) begin
      if (wb.Flush) begin
        wb.W_Valid <= 1'b0;
        wb.RegWr   <= 1'b0;
        wb.AddrErr <= 1'b0;
        wb.Rw      <= '0;
        wb.busW    <= '0;
      end else if (!wb.Stall) begin
        wb.W_Valid <= wb.M_Valid;
        wb.Rw      <= wb.M_Rw;
        wb.busW    <= wb.M_MemtoReg ? ext_data : wb.M_AluOut;
        wb.RegWr   <= wb.M_Valid & wb.M_RegWr & (wb.M_Rw != '0) & ~misaligned;
        wb.AddrErr <= wb.M_Valid & misaligned;
      end
    end
  end

`ifdef WB_RETIRE_CNT_EN
  logic [31:0] retire_cnt;

  // Count every valid instruction entering WB, misaligned loads included
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      retire_cnt <= '0;
    end else if (capture && wb.M_Valid) begin
      retire_cnt <= retire_cnt + 32'd1;
    end
  end

  assign wb.RetireCnt = retire_cnt;
`else
  assign wb.RetireCnt = 32'd0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed test-plan cases with literal
// expectations plus randomized traffic against a behavioural model.
module tb_wb_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;

  wb_stage_if #(.DW(32), .AW(5)) bus ();

  wb_stage #(.DW(32), .AW(5)) dut (
    .Clk (clk),
    .Rst (rst),
    .wb  (bus)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // behavioural model of what the register-file port must show
  logic        m_valid;
  logic        m_regwr;
  logic        m_err;
  logic [4:0]  m_rw;
  logic [31:0] m_busw;
  logic [31:0] m_cnt;

  function automatic logic [31:0] ref_ext(logic [31:0] raw, int op, int a);
    logic [31:0] b;
    logic [31:0] h;
    b = (raw >> (8 * a)) & 32'h0000_00FF;
    h = (raw >> (16 * (a / 2))) & 32'h0000_FFFF;
    case (op)
      1: return (b >= 32'h80) ? (b | 32'hFFFF_FF00) : b;
      2: return b;
      3: return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
      4: return h;
      default: return raw;
    endcase
  endfunction

  function automatic bit ref_mis(int op, int a);
    if (op == 3 || op == 4) return (a % 2) == 1;
    if (op == 1 || op == 2) return 1'b0;
    return a != 0;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_regwr = 0; m_err = 0; m_rw = 0; m_busw = 0; m_cnt = 0;
  endtask

  task automatic model_edge();
    bit mis;
    int a;
    if (rst) begin
      model_reset();
    end else if (bus.Run) begin
      if (bus.Flush) begin
        m_valid = 0; m_regwr = 0; m_err = 0; m_rw = 0; m_busw = 0;
      end else if (!bus.Stall) begin
        a   = int'(bus.M_AluOut % 4);
        mis = bus.M_MemtoReg && ref_mis(int'(bus.M_LoadOp), a);
        m_valid = bus.M_Valid;
        m_rw    = bus.M_Rw;
        m_busw  = bus.M_MemtoReg ? ref_ext(bus.M_MemData, int'(bus.M_LoadOp), a)
                                 : bus.M_AluOut;
        m_regwr = bus.M_Valid && bus.M_RegWr && (bus.M_Rw != 0) && !mis;
        m_err   = bus.M_Valid && mis;
        if (bus.M_Valid) m_cnt = m_cnt + 1;
      end
    end
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_model();
    logic [31:0] exp_cnt;
`ifdef WB_RETIRE_CNT_EN
    exp_cnt = m_cnt;
`else
    exp_cnt = 32'd0;
`endif
    chk("W_Valid",   {31'd0, bus.W_Valid}, {31'd0, m_valid});
    chk("RegWr",     {31'd0, bus.RegWr},   {31'd0, m_regwr});
    chk("AddrErr",   {31'd0, bus.AddrErr}, {31'd0, m_err});
    chk("Rw",        {27'd0, bus.Rw},      {27'd0, m_rw});
    chk("busW",      bus.busW,             m_busw);
    chk("RetireCnt", bus.RetireCnt,        exp_cnt);
  endtask

  // one clock: model follows the edge, outputs compared 1 time unit later
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk_model();
  endtask

  task automatic ctl(logic run, logic stall, logic flush);
    bus.Run = run; bus.Stall = stall; bus.Flush = flush;
  endtask

  task automatic drive(logic v, logic rw_en, logic m2r, logic [2:0] op,
                       logic [4:0] rw, logic [31:0] alu, logic [31:0] mem);
    bus.M_Valid = v; bus.M_RegWr = rw_en; bus.M_MemtoReg = m2r;
    bus.M_LoadOp = op; bus.M_Rw = rw; bus.M_AluOut = alu; bus.M_MemData = mem;
  endtask

  task automatic load(logic [2:0] op, logic [31:0] addr);
    drive(1, 1, 1, op, 5'd7, addr, 32'h80FF_7F01);
    step();
  endtask

  initial begin
    model_reset();
    ctl(1, 0, 0);
    drive(0, 0, 0, 3'd0, 5'd0, 32'd0, 32'd0);

    // reset held across edges
    repeat (2) step();
    #3 rst = 1'b0;

    // ALU result write
    drive(1, 1, 0, 3'd0, 5'd5, 32'h1234_5678, 32'hDEAD_BEEF);
    step();
    chk("alu_rw",    {27'd0, bus.Rw}, 32'd5);
    chk("alu_regwr", {31'd0, bus.RegWr}, 32'd1);
    chk("alu_busw",  bus.busW, 32'h1234_5678);

    // load extraction on 0x80FF7F01
    load(3'd1, 32'h0000_0102);
    chk("lb_a2", bus.busW, 32'hFFFF_FFFF);
    load(3'd2, 32'h0000_0103);
    chk("lbu_a3", bus.busW, 32'h0000_0080);
    load(3'd3, 32'h0000_0102);
    chk("lh_a2", bus.busW, 32'hFFFF_80FF);
    load(3'd4, 32'h0000_0100);
    chk("lhu_a0", bus.busW, 32'h0000_7F01);
    chk("lhu_regwr", {31'd0, bus.RegWr}, 32'd1);

    // write to r0 suppressed but still valid
    drive(1, 1, 0, 3'd0, 5'd0, 32'h0000_00AA, 32'd0);
    step();
    chk("r0_regwr", {31'd0, bus.RegWr}, 32'd0);
    chk("r0_valid", {31'd0, bus.W_Valid}, 32'd1);

    // misaligned LW: error for one cycle only
    drive(1, 1, 1, 3'd0, 5'd9, 32'h0000_1002, 32'h1111_2222);
    step();
    chk("mis_regwr", {31'd0, bus.RegWr}, 32'd0);
    chk("mis_err",   {31'd0, bus.AddrErr}, 32'd1);
    drive(1, 1, 0, 3'd0, 5'd9, 32'h0000_0004, 32'd0);
    step();
    chk("mis_err_clr", {31'd0, bus.AddrErr}, 32'd0);

    // stall holds for three cycles while inputs change
    drive(1, 1, 0, 3'd0, 5'd3, 32'hCAFE_0001, 32'd0);
    step();
    ctl(1, 1, 0);
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, 3'd0, 5'd4, 32'h0BAD_0000 + i, 32'd0);
      step();
      chk("stall_busw", bus.busW, 32'hCAFE_0001);
      chk("stall_rw", {27'd0, bus.Rw}, 32'd3);
    end

    // flush wins over stall
    ctl(1, 1, 1);
    step();
    chk("flush_valid", {31'd0, bus.W_Valid}, 32'd0);
    chk("flush_regwr", {31'd0, bus.RegWr}, 32'd0);

    // Run=0 freezes even with flush
    ctl(1, 0, 0);
    drive(1, 1, 0, 3'd0, 5'd12, 32'h5555_AAAA, 32'd0);
    step();
    ctl(0, 0, 1);
    step();
    chk("run0_busw",  bus.busW, 32'h5555_AAAA);
    chk("run0_valid", {31'd0, bus.W_Valid}, 32'd1);

    // async reset mid-stall while RegWr is high
    ctl(1, 1, 0);
    step();
    #2 rst = 1'b1;
    model_reset();
    #1;
    chk("rst_regwr", {31'd0, bus.RegWr}, 32'd0);
    chk("rst_valid", {31'd0, bus.W_Valid}, 32'd0);
    chk("rst_busw",  bus.busW, 32'd0);
    chk("rst_rw",    {27'd0, bus.Rw}, 32'd0);
    chk_model();
    #3 rst = 1'b0;

    // 10 valid captures with 2 stalls and 1 flush interleaved
    for (int i = 0; i < 13; i++) begin
      if (i == 3 || i == 8)  ctl(1, 1, 0);
      else if (i == 5)       ctl(1, 0, 1);
      else                   ctl(1, 0, 0);
      drive(1, 1, 0, 3'd0, 5'(i + 1), 32'(i), 32'd0);
      step();
    end
`ifdef WB_RETIRE_CNT_EN
    chk("retire_10", bus.RetireCnt, 32'd10);
    ctl(1, 1, 0);
    force dut.retire_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.retire_cnt;
    m_cnt = 32'hFFFF_FFFF;
    ctl(1, 0, 0);
    drive(1, 1, 0, 3'd0, 5'd1, 32'd0, 32'd0);
    step();
    chk("retire_wrap", bus.RetireCnt, 32'd0);
`endif

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      ctl(($urandom_range(0, 9) != 0), ($urandom_range(0, 5) == 0),
          ($urandom_range(0, 9) == 0));
      drive(1'($urandom), 1'($urandom), 1'($urandom), 3'($urandom_range(0, 7)),
            5'($urandom), $urandom, $urandom);
      if ($urandom_range(0, 199) == 0) begin
        #2 rst = 1'b1;
        model_reset();
        #1;
        chk_model();
        #2 rst = 1'b0;
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
